// File: rtl/mc_ctrl_ws.sv
// Multicycle MIPS control FSM with memory ready/wait handshake, bus timeout and
// performance counters. Define PERF_CNT_EN to build the six counters; otherwise they read 0.
module mc_ctrl_ws #(
    parameter int CNT_W   = 32,
    parameter int TIMEOUT = 0,   // 0 disables the timeout; must be < 2**TO_W
    parameter int TO_W    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       op,
    input  logic [5:0]       func,
    input  logic             mem_ready,
    output logic [1:0]       RegDst,
    output logic             ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       MemtoReg,
    output logic             RegWrite,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             IRWrite,
    output logic             PCWrite,
    output logic             PCWriteCond,
    output logic [1:0]       PCSource,
    output logic [2:0]       ALUOp,
    output logic             bus_err,
    output logic             illegal,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] inst_cnt,
    output logic [CNT_W-1:0] br_cnt,
    output logic [CNT_W-1:0] ld_cnt,
    output logic [CNT_W-1:0] st_cnt,
    output logic [CNT_W-1:0] stall_cnt
);

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR, S_REXEC,
        S_RWB, S_BRANCH, S_IEXEC, S_IWB, S_JAL, S_JUMP, S_JR
    } state_t;

    state_t          state_q, state_d;
    logic [TO_W-1:0] wait_q, wait_d;
    logic            bus_err_q, bus_err_d;
    logic            mem_state;
    logic            timeout;

    assign mem_state = (state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR);
    // A ready in the same cycle as the limit is reached still completes the access.
    assign timeout   = (TIMEOUT != 0) && mem_state && !mem_ready && (wait_q == TO_W'(TIMEOUT));

    always_comb begin
        // NOTE: every output gets a default first so no path through the case infers a latch.
        state_d     = state_q;
        RegDst      = 2'b00;
        ALUSrcA     = 1'b0;
        ALUSrcB     = 2'b00;
        MemtoReg    = 2'b00;
        RegWrite    = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        PCSource    = 2'b00;
        ALUOp       = 3'b000;
        illegal     = 1'b0;
        unique case (state_q)
            S_FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = 2'b01;
                IRWrite = mem_ready;
                PCWrite = mem_ready;
                if (mem_ready) state_d = S_DECODE;
            end
            S_DECODE: begin
                ALUSrcB = 2'b11;
                case (op)
                    6'h23, 6'h2B:               state_d = S_MEMADR;
                    6'h00:                      state_d = (func == 6'h08) ? S_JR : S_REXEC;
                    6'h04, 6'h05:               state_d = S_BRANCH;
                    6'h09, 6'h0F, 6'h0A, 6'h0B: state_d = S_IEXEC;
                    6'h03:                      state_d = S_JAL;
                    6'h02:                      state_d = S_JUMP;
                    default: begin
                        illegal = 1'b1;
                        state_d = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                state_d = (op == 6'h23) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                MemRead = 1'b1;
                if (mem_ready) state_d = S_MEMWB;
                else if (timeout) state_d = S_FETCH;
            end
            S_MEMWB: begin
                RegWrite = 1'b1;
                MemtoReg = 2'b01;
                state_d  = S_FETCH;
            end
            S_MEMWR: begin
                MemWrite = 1'b1;
                if (mem_ready || timeout) state_d = S_FETCH;
            end
            S_REXEC: begin
                ALUSrcA = 1'b1;
                ALUOp   = 3'b010;
                state_d = S_RWB;
            end
            S_RWB: begin
                RegWrite = 1'b1;
                RegDst   = 2'b01;
                MemtoReg = (func == 6'h00) ? 2'b10 : 2'b00;
                state_d  = S_FETCH;
            end
            S_BRANCH: begin
                ALUSrcA     = 1'b1;
                ALUOp       = 3'b001;
                PCWriteCond = 1'b1;
                PCSource    = 2'b01;
                state_d     = S_FETCH;
            end
            S_IEXEC: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                case (op)
                    6'h0F:   ALUOp = 3'b011;
                    6'h0A:   ALUOp = 3'b100;
                    6'h0B:   ALUOp = 3'b101;
                    default: ALUOp = 3'b000;
                endcase
                state_d = S_IWB;
            end
            S_IWB: begin
                RegWrite = 1'b1;
                state_d  = S_FETCH;
            end
            S_JAL: begin
                RegWrite = 1'b1;
                RegDst   = 2'b10;
                MemtoReg = 2'b11;
                PCWrite  = 1'b1;
                PCSource = 2'b10;
                state_d  = S_FETCH;
            end
            S_JUMP: begin
                PCWrite  = 1'b1;
                PCSource = 2'b10;
                state_d  = S_FETCH;
            end
            S_JR: begin
                PCWrite  = 1'b1;
                PCSource = 2'b11;
                state_d  = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase
        // Non-memory states hold the counter at 0, so every memory state is entered with it clear.
        wait_d    = (mem_state && !mem_ready && !timeout) ? wait_q + TO_W'(1) : '0;
        bus_err_d = timeout;
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so all flops update together.
        if (rst) begin
            state_q   <= S_FETCH;
            wait_q    <= '0;
            bus_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            bus_err_q <= bus_err_d;
        end
    end

    assign bus_err = bus_err_q;

`ifdef PERF_CNT_EN
    logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d, inst_cnt_q, inst_cnt_d, br_cnt_q, br_cnt_d;
    logic [CNT_W-1:0] ld_cnt_q, ld_cnt_d, st_cnt_q, st_cnt_d, stall_cnt_q, stall_cnt_d;
    logic             is_br;

    assign is_br = (state_q == S_BRANCH) || (state_q == S_JAL) ||
                   (state_q == S_JUMP)   || (state_q == S_JR);

    always_comb begin
        cycle_cnt_d = cycle_cnt_q + CNT_W'(1);
        inst_cnt_d  = inst_cnt_q  + CNT_W'(state_q == S_FETCH && mem_ready);
        br_cnt_d    = br_cnt_q    + CNT_W'(is_br);
        ld_cnt_d    = ld_cnt_q    + CNT_W'(state_q == S_MEMRD && mem_ready);
        st_cnt_d    = st_cnt_q    + CNT_W'(state_q == S_MEMWR && mem_ready);
        stall_cnt_d = stall_cnt_q + CNT_W'(mem_state && !mem_ready);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cycle_cnt_q <= '0;
            inst_cnt_q  <= '0;
            br_cnt_q    <= '0;
            ld_cnt_q    <= '0;
            st_cnt_q    <= '0;
            stall_cnt_q <= '0;
        end else begin
            cycle_cnt_q <= cycle_cnt_d;
            inst_cnt_q  <= inst_cnt_d;
            br_cnt_q    <= br_cnt_d;
            ld_cnt_q    <= ld_cnt_d;
            st_cnt_q    <= st_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign cycle_cnt = cycle_cnt_q;
    assign inst_cnt  = inst_cnt_q;
    assign br_cnt    = br_cnt_q;
    assign ld_cnt    = ld_cnt_q;
    assign st_cnt    = st_cnt_q;
    assign stall_cnt = stall_cnt_q;
`else
    assign cycle_cnt = '0;
    assign inst_cnt  = '0;
    assign br_cnt    = '0;
    assign ld_cnt    = '0;
    assign st_cnt    = '0;
    assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_mc_ctrl_ws.sv
// Bench for mc_ctrl_ws: each instruction is expanded into its expected phase sequence
// (with drawn memory latencies) and every cycle's control word and counters are checked.
module tb_mc_ctrl_ws;

    localparam int TO    = 4;
    localparam int CNT_W = 32;
`ifdef PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    typedef enum {
        P_FETCH, P_DECODE, P_MEMADR, P_MEMRD, P_MEMWB, P_MEMWR, P_REXEC,
        P_RWB, P_BRANCH, P_IEXEC, P_IWB, P_JAL, P_JUMP, P_JR
    } phase_e;

    typedef struct packed {
        logic [1:0] reg_dst;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] mem_to_reg;
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       pc_write;
        logic       pc_write_cond;
        logic [1:0] pc_source;
        logic [2:0] alu_op;
        logic       illegal;
    } ctrl_t;

    typedef struct {
        phase_e     ph;
        logic       rdy;
        bit         to;
        logic [5:0] op;
        logic [5:0] func;
    } step_t;

    logic             clk, rst, mem_ready;
    logic [5:0]       op, func;
    logic [1:0]       RegDst, ALUSrcB, MemtoReg, PCSource;
    logic             ALUSrcA, RegWrite, MemRead, MemWrite, IRWrite, PCWrite, PCWriteCond;
    logic [2:0]       ALUOp;
    logic             bus_err, illegal;
    logic [CNT_W-1:0] cycle_cnt, inst_cnt, br_cnt, ld_cnt, st_cnt, stall_cnt;

    mc_ctrl_ws #(.CNT_W(CNT_W), .TIMEOUT(TO), .TO_W(8)) dut (
        .clk(clk), .rst(rst), .op(op), .func(func), .mem_ready(mem_ready),
        .RegDst(RegDst), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .MemtoReg(MemtoReg),
        .RegWrite(RegWrite), .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .PCSource(PCSource), .ALUOp(ALUOp),
        .bus_err(bus_err), .illegal(illegal),
        .cycle_cnt(cycle_cnt), .inst_cnt(inst_cnt), .br_cnt(br_cnt),
        .ld_cnt(ld_cnt), .st_cnt(st_cnt), .stall_cnt(stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_vec  = 0;
    int unsigned n_fail = 0;
    step_t       plan[$];
    logic [5:0]  cur_op, cur_func;
    bit          pend_berr;
    int unsigned m_cycle, m_inst, m_br, m_ld, m_st, m_stall;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] cexp(input int unsigned v);
        return PERF ? v : 32'd0;
    endfunction

    // Expected control word for each phase, straight from the control table.
    function automatic ctrl_t exp_ctrl(input phase_e p, input logic [5:0] o,
                                       input logic [5:0] f, input logic rdy);
        ctrl_t c;
        c = '0;
        case (p)
            P_FETCH:  begin c.mem_read = 1; c.alu_src_b = 2'b01; c.ir_write = rdy; c.pc_write = rdy; end
            P_DECODE: begin
                c.alu_src_b = 2'b11;
                c.illegal   = !(o inside {6'h23, 6'h2B, 6'h00, 6'h04, 6'h05, 6'h09,
                                          6'h0F, 6'h0A, 6'h0B, 6'h03, 6'h02});
            end
            P_MEMADR: begin c.alu_src_a = 1; c.alu_src_b = 2'b10; end
            P_MEMRD:  c.mem_read = 1;
            P_MEMWB:  begin c.reg_write = 1; c.mem_to_reg = 2'b01; end
            P_MEMWR:  c.mem_write = 1;
            P_REXEC:  begin c.alu_src_a = 1; c.alu_op = 3'b010; end
            P_RWB:    begin c.reg_write = 1; c.reg_dst = 2'b01; c.mem_to_reg = (f == 6'h00) ? 2'b10 : 2'b00; end
            P_BRANCH: begin c.alu_src_a = 1; c.alu_op = 3'b001; c.pc_write_cond = 1; c.pc_source = 2'b01; end
            P_IEXEC:  begin
                c.alu_src_a = 1;
                c.alu_src_b = 2'b10;
                c.alu_op    = (o == 6'h0F) ? 3'b011 : (o == 6'h0A) ? 3'b100 : (o == 6'h0B) ? 3'b101 : 3'b000;
            end
            P_IWB:    c.reg_write = 1;
            P_JAL:    begin c.reg_write = 1; c.reg_dst = 2'b10; c.mem_to_reg = 2'b11; c.pc_write = 1; c.pc_source = 2'b10; end
            P_JUMP:   begin c.pc_write = 1; c.pc_source = 2'b10; end
            P_JR:     begin c.pc_write = 1; c.pc_source = 2'b11; end
            default:  c = '0;
        endcase
        return c;
    endfunction

    task automatic add_step(input phase_e p, input logic rdy, input bit to);
        step_t s;
        s.ph = p; s.rdy = rdy; s.to = to; s.op = cur_op; s.func = cur_func;
        plan.push_back(s);
    endtask

    // A memory phase waiting lat cycles: completes if lat <= TO, otherwise
    // times out after TO+1 unready cycles.
    task automatic add_mem(input phase_e p, input int lat, output bit ok);
        if (lat > TO) begin
            for (int i = 0; i <= TO; i++) add_step(p, 1'b0, i == TO);
            ok = 1'b0;
        end else begin
            for (int i = 0; i < lat; i++) add_step(p, 1'b0, 1'b0);
            add_step(p, 1'b1, 1'b0);
            ok = 1'b1;
        end
    endtask

    function automatic logic rnd_bit();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic plan_instr(input logic [5:0] o, input logic [5:0] f, input int lat_f, input int lat_m);
        bit ok;
        int lat;
        cur_op = o;
        cur_func = f;
        lat = (lat_f < 0) ? int'($urandom_range(0, 6)) : lat_f;
        add_mem(P_FETCH, lat, ok);
        while (!ok) add_mem(P_FETCH, int'($urandom_range(0, 6)), ok);
        add_step(P_DECODE, rnd_bit(), 1'b0);
        lat = (lat_m < 0) ? int'($urandom_range(0, 6)) : lat_m;
        case (o)
            6'h23: begin
                add_step(P_MEMADR, rnd_bit(), 1'b0);
                add_mem(P_MEMRD, lat, ok);
                if (ok) add_step(P_MEMWB, rnd_bit(), 1'b0);
            end
            6'h2B: begin
                add_step(P_MEMADR, rnd_bit(), 1'b0);
                add_mem(P_MEMWR, lat, ok);
            end
            6'h00: begin
                if (f == 6'h08) add_step(P_JR, rnd_bit(), 1'b0);
                else begin
                    add_step(P_REXEC, rnd_bit(), 1'b0);
                    add_step(P_RWB, rnd_bit(), 1'b0);
                end
            end
            6'h04, 6'h05: add_step(P_BRANCH, rnd_bit(), 1'b0);
            6'h09, 6'h0F, 6'h0A, 6'h0B: begin
                add_step(P_IEXEC, rnd_bit(), 1'b0);
                add_step(P_IWB, rnd_bit(), 1'b0);
            end
            6'h03: add_step(P_JAL, rnd_bit(), 1'b0);
            6'h02: add_step(P_JUMP, rnd_bit(), 1'b0);
            default: ;
        endcase
    endtask

    task automatic check_counters(input string pfx);
        check({pfx, "cycle_cnt"}, cycle_cnt, cexp(m_cycle));
        check({pfx, "inst_cnt"},  inst_cnt,  cexp(m_inst));
        check({pfx, "br_cnt"},    br_cnt,    cexp(m_br));
        check({pfx, "ld_cnt"},    ld_cnt,    cexp(m_ld));
        check({pfx, "st_cnt"},    st_cnt,    cexp(m_st));
        check({pfx, "stall_cnt"}, stall_cnt, cexp(m_stall));
    endtask

    // Entered and left on a falling edge; one planned step per clock.
    task automatic run_plan(input int max_steps);
        step_t s;
        ctrl_t obs;
        int    n;
        n = 0;
        while (plan.size() > 0 && n < max_steps) begin
            s = plan.pop_front();
            op = s.op;
            func = s.func;
            mem_ready = s.rdy;
            #1;
            obs = {RegDst, ALUSrcA, ALUSrcB, MemtoReg, RegWrite, MemRead, MemWrite,
                   IRWrite, PCWrite, PCWriteCond, PCSource, ALUOp, illegal};
            check({"ctrl_", s.ph.name()}, 32'(obs), 32'(exp_ctrl(s.ph, s.op, s.func, s.rdy)));
            check("bus_err", 32'(bus_err), 32'(pend_berr));
            check_counters("");
            m_cycle++;
            if (s.ph == P_FETCH && s.rdy) m_inst++;
            if (s.ph inside {P_BRANCH, P_JAL, P_JUMP, P_JR}) m_br++;
            if (s.ph == P_MEMRD && s.rdy) m_ld++;
            if (s.ph == P_MEMWR && s.rdy) m_st++;
            if (s.ph inside {P_FETCH, P_MEMRD, P_MEMWR} && !s.rdy) m_stall++;
            pend_berr = s.to;
            n++;
            @(negedge clk);
        end
    endtask

    // Reset is held for two edges; the cycle between them must already show FETCH and clear counters.
    task automatic do_reset();
        rst = 1'b1;
        mem_ready = 1'b0;
        @(negedge clk);
        #1;
        check("rst_ctrl", 32'({RegDst, ALUSrcA, ALUSrcB, MemtoReg, RegWrite, MemRead, MemWrite,
                               IRWrite, PCWrite, PCWriteCond, PCSource, ALUOp, illegal}),
              32'(exp_ctrl(P_FETCH, op, func, 1'b0)));
        check("rst_MemRead", 32'(MemRead), 32'd1);
        check("rst_bus_err", 32'(bus_err), 32'd0);
        m_cycle = 0; m_inst = 0; m_br = 0; m_ld = 0; m_st = 0; m_stall = 0;
        check_counters("rst_");
        @(negedge clk);
        rst = 1'b0;
        pend_berr = 1'b0;
        plan.delete();
    endtask

    logic [5:0] ops[14]  = '{6'h23, 6'h2B, 6'h00, 6'h00, 6'h04, 6'h05, 6'h09,
                             6'h0F, 6'h0A, 6'h0B, 6'h03, 6'h02, 6'h3F, 6'h11};
    logic [5:0] funcs[4] = '{6'h00, 6'h08, 6'h21, 6'h2A};

    initial begin
        rst = 1'b1;
        op = 6'h00;
        func = 6'h00;
        mem_ready = 1'b0;
        do_reset();

        // addu with zero-latency memory: four cycles, one instruction
        plan_instr(6'h00, 6'h21, 0, 0);
        run_plan(1000);
        check("addu_cycle_cnt", cycle_cnt, cexp(4));
        check("addu_inst_cnt",  inst_cnt,  cexp(1));

        // lw with three unready cycles in MEMRD
        do_reset();
        plan_instr(6'h23, 6'h00, 0, 3);
        run_plan(1000);
        check("lw_stall_cnt", stall_cnt, cexp(3));
        check("lw_ld_cnt",    ld_cnt,    cexp(1));

        // sw that never gets ready: timeout, bus_err on the following fetch
        do_reset();
        plan_instr(6'h2B, 6'h00, 0, 20);
        plan_instr(6'h00, 6'h21, 0, 0);
        run_plan(1000);
        check("sw_to_st_cnt",    st_cnt,    cexp(0));
        check("sw_to_stall_cnt", stall_cnt, cexp(TO + 1));

        // beq, then an illegal opcode
        do_reset();
        plan_instr(6'h04, 6'h00, 0, 0);
        run_plan(1000);
        check("beq_br_cnt", br_cnt, cexp(1));
        plan_instr(6'h3F, 6'h00, 0, 0);
        plan_instr(6'h02, 6'h00, 1, 0);
        run_plan(1000);

        // reset asserted while waiting in MEMRD
        do_reset();
        plan_instr(6'h23, 6'h00, 0, 3);
        run_plan(4);
        do_reset();

        // randomized instruction stream with random latencies (including timeouts)
        for (int i = 0; i < 80; i++) begin
            plan_instr(ops[$urandom_range(0, 13)], funcs[$urandom_range(0, 3)], -1, -1);
            run_plan(1000);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
